// File: rtl/fetch_phase_pkg.sv
// Shared fetch-stage types and constants: NOP encoding, FSM states and the
// buffered {inst, pc} entry.
package fetch_phase_pkg;

  localparam int XLEN = 32;
  // Outstanding/drop counters; the memory must keep fewer than 2**CNT_W requests in flight.
  localparam int CNT_W = 8;

  localparam logic [XLEN-1:0] INST_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetch_entry_t with flush and occupancy count.
// The head entry is visible combinationally so decode sees it without a bubble.
module fetch_fifo
  import fetch_phase_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  output fetch_entry_t head,
  output logic [CW-1:0] count,
  output logic         empty,
  output logic         full
);

  fetch_entry_t mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == CW'(DEPTH));
  assign count   = count_reg;
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      count_reg <= count_reg + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/fetch_phase.sv
// Instruction-fetch stage: owns the PC, issues credit-limited imem requests,
// buffers responses for decode and drops wrong-path data after redirects.
// Optional macro FETCH_BYPASS_EN forwards a response straight to decode when the buffer is empty.
module fetch_phase
  import fetch_phase_pkg::*;
#(
  parameter int               WIDTH      = 32,
  parameter logic [WIDTH-1:0] RESET_PC   = 32'h0000_0000,
  parameter int               FIFO_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req_valid,
  input  logic             imem_req_ready,
  output logic [WIDTH-1:0] imem_req_addr,
  input  logic             imem_rsp_valid,
  input  logic [WIDTH-1:0] imem_rsp_data,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_pc,
  output logic             inst_valid,
  input  logic             inst_ready,
  output logic [WIDTH-1:0] inst,
  output logic [WIDTH-1:0] inst_pc
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e     state_reg, state_next;
  logic [WIDTH-1:0] pc_reg, pc_next;
  logic [CNT_W-1:0] outstanding_reg, outstanding_next;
  logic [CNT_W-1:0] drop_reg, drop_next;
  logic [WIDTH-1:0] inst_pc_last_reg;

  fetch_entry_t  buf_head, buf_push_data;
  fetch_entry_t  tag_head, tag_push_data;
  logic [CW-1:0] buf_count, tag_count;
  logic          buf_empty, buf_full, tag_empty, tag_full;
  logic          buf_push, buf_pop, tag_pop;
  logic          req_fire, rsp_live, bypass;
  logic [CNT_W:0] credit_used;
  logic          unused_signals;

  // Live requests plus buffered entries must stay below the buffer depth so
  // every live response is guaranteed a slot.
  assign credit_used    = {1'b0, outstanding_reg - drop_reg} + (CNT_W + 1)'(buf_count);
  assign imem_req_valid = (state_reg != S_IDLE) && !redirect_valid &&
                          (credit_used < (CNT_W + 1)'(FIFO_DEPTH));
  assign imem_req_addr  = pc_reg;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign rsp_live = imem_rsp_valid && (drop_reg == '0) && !redirect_valid;
  assign tag_pop  = imem_rsp_valid && (drop_reg == '0);

`ifdef FETCH_BYPASS_EN
  assign bypass = buf_empty && rsp_live;
`else
  assign bypass = 1'b0;
`endif

  assign buf_push      = rsp_live && !(bypass && inst_ready);
  assign buf_pop       = !buf_empty && inst_ready;
  assign buf_push_data = '{inst: imem_rsp_data, pc: tag_head.pc};
  assign tag_push_data = '{inst: '0, pc: pc_reg};

  assign inst_valid = !buf_empty || bypass;

  always_comb begin
    inst    = INST_NOP;
    inst_pc = inst_pc_last_reg;
    if (bypass) begin
      inst    = imem_rsp_data;
      inst_pc = tag_head.pc;
    end else if (!buf_empty) begin
      inst    = buf_head.inst;
      inst_pc = buf_head.pc;
    end
  end

  always_comb begin
    state_next       = state_reg;
    pc_next          = pc_reg;
    outstanding_next = outstanding_reg + CNT_W'(req_fire) - CNT_W'(imem_rsp_valid);
    drop_next        = drop_reg;
    if (redirect_valid) begin
      pc_next   = {redirect_pc[WIDTH-1:2], 2'b00};
      // Everything still in flight after this cycle's response is wrong-path.
      drop_next = outstanding_reg - CNT_W'(imem_rsp_valid);
    end else begin
      if (req_fire) begin
        pc_next = pc_reg + WIDTH'(4);
      end
      if (imem_rsp_valid && (drop_reg != '0)) begin
        drop_next = drop_reg - CNT_W'(1);
      end
    end
    case (state_reg)
      S_IDLE:  state_next = S_RUN;
      S_RUN,
      S_DRAIN: state_next = (drop_next != '0) ? S_DRAIN : S_RUN;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg        <= S_IDLE;
      pc_reg           <= RESET_PC;
      outstanding_reg  <= '0;
      drop_reg         <= '0;
      inst_pc_last_reg <= '0;
    end else begin
      state_reg       <= state_next;
      pc_reg          <= pc_next;
      outstanding_reg <= outstanding_next;
      drop_reg        <= drop_next;
      if (inst_valid) begin
        inst_pc_last_reg <= inst_pc;
      end
    end
  end

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_inst_buf (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (buf_push),
    .push_data (buf_push_data),
    .pop       (buf_pop),
    .head      (buf_head),
    .count     (buf_count),
    .empty     (buf_empty),
    .full      (buf_full)
  );

  // Tracks addresses of live requests; only the pc field is meaningful.
  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_tag_queue (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (req_fire),
    .push_data (tag_push_data),
    .pop       (tag_pop),
    .head      (tag_head),
    .count     (tag_count),
    .empty     (tag_empty),
    .full      (tag_full)
  );

  assign unused_signals = ^{tag_head.inst, tag_count, tag_empty, tag_full, buf_full, redirect_pc[1:0]};

endmodule

// File: tb/tb_fetch_phase.sv
// Directed bench for fetch_phase: cycle-exact vector table after reset plus
// back-pressure, redirect, coincident-redirect and PC-wrap sequences.
`timescale 1ns/1ps
module tb_fetch_phase;
  import fetch_phase_pkg::*;

  localparam logic [31:0] RPC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid, inst_ready;
  logic [31:0] inst, inst_pc;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  fetch_phase #(.WIDTH(32), .RESET_PC(RPC), .FIFO_DEPTH(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return ~a ^ 32'h1357_0000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Memory model: in-order responses, fixed latency from acceptance.
  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;
  pend_t       pend[$];
  logic [31:0] acc_log[$];
  int          mem_cyc   = 0;
  int          mem_lat   = 1;
  int          acc_count = 0;

  initial begin
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    forever begin
      @(posedge clk);
      #1;
      mem_cyc++;
      if (rst) begin
        pend.delete();
        imem_rsp_valid = 1'b0;
      end else if (pend.size() > 0 && pend[0].due <= mem_cyc) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(pend[0].addr);
        pend.delete(0);
      end else begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!rst && imem_req_valid && imem_req_ready) begin
        pend.push_back('{addr: imem_req_addr, due: mem_cyc + mem_lat});
        acc_log.push_back(imem_req_addr);
        acc_count++;
      end
    end
  end

  // Delivery scoreboard: decode must see consecutive PCs from the last redirect target.
  logic [31:0] exp_pc = RPC;
  int          deliv  = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (inst_valid && inst_ready) begin
          check("deliver_pc", inst_pc, exp_pc);
          check("deliver_inst", inst, mem_word(exp_pc));
          exp_pc = exp_pc + 32'd4;
          deliv++;
        end
        if (redirect_valid) begin
          exp_pc = redirect_pc & ~32'h3;
        end
      end
    end
  end

  task automatic do_reset();
    step();
    rst            = 1'b1;
    redirect_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst       = 1'b0;
    exp_pc    = RPC;
    acc_count = 0;
    acc_log.delete();
  endtask

  task automatic wait_deliv(input int target, input string name);
    int n = 0;
    while (deliv < target && n < 40) begin
      step();
      n++;
    end
    checks++;
    if (deliv < target) begin
      fails++;
      $display("FAIL %s: delivered %0d required %0d", name, deliv, target);
    end else begin
      $display("ok   %s: delivered %0d", name, deliv);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        req_valid;
    logic [31:0] req_addr;
    logic        inst_valid;
    logic [31:0] inst_pc;
  } vec_t;
  vec_t vt[8];

  initial begin
    int base;
    int n;
    inst_ready     = 1'b1;
    imem_req_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;

`ifdef FETCH_BYPASS_EN
    vt[0] = '{1'b0, 32'h100, 1'b0, 32'h000};
    vt[1] = '{1'b1, 32'h100, 1'b0, 32'h000};
    vt[2] = '{1'b1, 32'h104, 1'b1, 32'h100};
    vt[3] = '{1'b1, 32'h108, 1'b1, 32'h104};
    vt[4] = '{1'b1, 32'h10C, 1'b1, 32'h108};
    vt[5] = '{1'b1, 32'h110, 1'b1, 32'h10C};
    vt[6] = '{1'b1, 32'h114, 1'b1, 32'h110};
    vt[7] = '{1'b1, 32'h118, 1'b1, 32'h114};
`else
    vt[0] = '{1'b0, 32'h100, 1'b0, 32'h000};
    vt[1] = '{1'b1, 32'h100, 1'b0, 32'h000};
    vt[2] = '{1'b1, 32'h104, 1'b0, 32'h000};
    vt[3] = '{1'b0, 32'h108, 1'b1, 32'h100};
    vt[4] = '{1'b1, 32'h108, 1'b1, 32'h104};
    vt[5] = '{1'b1, 32'h10C, 1'b0, 32'h104};
    vt[6] = '{1'b0, 32'h110, 1'b1, 32'h108};
    vt[7] = '{1'b1, 32'h110, 1'b1, 32'h10C};
`endif

    // Reset and stream, 1-cycle memory, decode always ready.
    mem_lat = 1;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check($sformatf("v%0d_req_valid", i), {31'b0, imem_req_valid}, {31'b0, vt[i].req_valid});
      check($sformatf("v%0d_req_addr", i), imem_req_addr, vt[i].req_addr);
      check($sformatf("v%0d_inst_valid", i), {31'b0, inst_valid}, {31'b0, vt[i].inst_valid});
      check($sformatf("v%0d_inst_pc", i), inst_pc, vt[i].inst_pc);
      check($sformatf("v%0d_inst", i), inst, vt[i].inst_valid ? mem_word(vt[i].inst_pc) : INST_NOP);
      step();
    end

    // Back-pressure: decode stalled from reset for 11 cycles.
    inst_ready = 1'b0;
    do_reset();
    for (int c = 0; c < 11; c++) begin
      @(negedge clk);
      if (c >= 3) begin
        check($sformatf("bp_hold_pc_c%0d", c), inst_pc, 32'h100);
      end
      step();
    end
    @(negedge clk);
    check("bp_accepts", acc_count, 32'd2);
    check("bp_inst_valid", {31'b0, inst_valid}, 32'd1);
    check("bp_req_valid", {31'b0, imem_req_valid}, 32'd0);
    check("bp_inst", inst, mem_word(32'h100));
    step();
    inst_ready = 1'b1;
    base = deliv;
    wait_deliv(base + 3, "bp_release");

    // Redirect with two responses in flight (3-cycle memory).
    mem_lat = 3;
    do_reset();
    repeat (3) step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h203;
    @(negedge clk);
    check("rd_accepts_before", acc_count, 32'd2);
    check("rd_req_suppressed", {31'b0, imem_req_valid}, 32'd0);
    step();
    redirect_valid = 1'b0;
    @(negedge clk);
    check("rd_drain_req_valid", {31'b0, imem_req_valid}, 32'd1);
    check("rd_drain_req_addr", imem_req_addr, 32'h200);
    base = deliv;
    wait_deliv(base + 2, "rd_new_path");

    // Redirect coinciding with a response and a decode pop.
    mem_lat    = 1;
    inst_ready = 1'b0;
    do_reset();
    repeat (3) step();
    inst_ready     = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h300;
    base = deliv;
    @(negedge clk);
    check("co_inst_valid", {31'b0, inst_valid}, 32'd1);
    check("co_inst_pc", inst_pc, 32'h100);
    step();
    redirect_valid = 1'b0;
    @(negedge clk);
    check("co_pop_done", deliv, base + 1);
    check("co_inst_valid_after", {31'b0, inst_valid}, 32'd0);
    check("co_req_valid", {31'b0, imem_req_valid}, 32'd1);
    check("co_req_addr", imem_req_addr, 32'h300);
    wait_deliv(base + 3, "co_new_path");

    // PC wrap at the top of the address space.
    do_reset();
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFE;
    step();
    redirect_valid = 1'b0;
    n = 0;
    while (acc_log.size() < 2 && n < 40) begin
      step();
      n++;
    end
    if (acc_log.size() >= 2) begin
      check("wrap_addr0", acc_log[0], 32'hFFFF_FFFC);
      check("wrap_addr1", acc_log[1], 32'h0000_0000);
    end else begin
      checks++;
      fails++;
      $display("FAIL wrap_accepts: got %0d required 2", acc_log.size());
    end
    base = deliv;
    wait_deliv(base + 2, "wrap_deliver");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/fetch_phase.md
Name: fetch_phase

Overview:
- Instruction-fetch stage that sits directly upstream of the decode stage.
- Owns the PC and issues word requests to instruction memory through a valid/ready request channel with an in-order response channel.
- Buffers returned instructions in a small FIFO and presents them to decode as {inst, inst_pc} under a valid/ready handshake.
- Accepts PC redirects (branch/jump/trap) from later stages and discards wrong-path instructions.

Parameters:
- WIDTH, 32, data/address width.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- FIFO_DEPTH, 2, instruction buffer entries; power of two, ≥2.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  asynchronous, active-high reset.
- imem_req_valid  output  1  fetch request valid.
- imem_req_ready  input  1  memory accepts request.
- imem_req_addr  output  WIDTH  word-aligned fetch address.
- imem_rsp_valid  input  1  response valid; in order, ≥1 cycle after acceptance, never back-pressured.
- imem_rsp_data  input  WIDTH  returned instruction.
- redirect_valid  input  1  flush and restart fetch.
- redirect_pc  input  WIDTH  new PC; bits [1:0] ignored, forced to 0.
- inst_valid  output  1  instruction available to decode.
- inst_ready  input  1  decode consumes instruction.
- inst  output  WIDTH  instruction word.
- inst_pc  output  WIDTH  PC of inst.

Behaviour:
- Reset values:
  - imem_req_valid=0, inst_valid=0.
  - imem_req_addr=RESET_PC, inst=INST_NOP, inst_pc=0.
  - PC=RESET_PC, FIFO empty, outstanding=0, drop=0, state=S_IDLE.
- Reset asserted mid-operation clears all state immediately; responses arriving during or after reset for pre-reset requests are not the block's concern.
- FSM:
  - S_IDLE: one cycle after reset release, then S_RUN.
  - S_RUN: normal fetch.
  - S_DRAIN: drop>0; wrong-path responses are discarded. Requests from the new PC may already issue in S_DRAIN.
  - S_DRAIN → S_RUN when the last dropped response arrives.
  - S_RUN → S_DRAIN on redirect when outstanding (after same-cycle response) is >0; otherwise stay in S_RUN.
- Credit rule: imem_req_valid = state≠S_IDLE && !redirect_valid && (outstanding_live + fifo_count) < FIFO_DEPTH.
  - outstanding_live = outstanding − drop. This guarantees every live response has a FIFO slot.
- Request handshake:
  - Request accepted when imem_req_valid && imem_req_ready.
  - On acceptance: PC += 4 (mod 2^WIDTH; wrap 32'hFFFF_FFFC → 0 is legal) and outstanding++.
  - imem_req_addr = PC.
- Response handling:
  - Each imem_rsp_valid decrements outstanding.
  - If drop>0: drop-- and the data is discarded.
  - Else: {imem_rsp_data, pc_tag} is pushed into the FIFO. pc_tag comes from an internal PC-tag queue tracking addresses of live outstanding requests.
- Decode handshake:
  - inst_valid = FIFO non-empty.
  - Pop on inst_valid && inst_ready.
  - inst/inst_pc come from the FIFO head; they hold stable while inst_valid && !inst_ready.
  - Push and pop in the same cycle are legal when full or empty.
- Redirect (takes priority over everything):
  - In that cycle: no request is issued.
  - At the edge:
    - PC ← {redirect_pc[WIDTH-1:2], 2'b00}.
    - FIFO and PC-tag queue cleared.
    - drop ← outstanding − (imem_rsp_valid ? 1 : 0).
    - The same-cycle response is discarded.
  - inst_valid falls the cycle after redirect; a same-cycle pop by decode is still honoured.
  - Back-to-back redirects: the later one wins; drop accumulates correctly.
- Latency: request accepted at cycle N with response at N+1 gives inst_valid at N+2 (bypass off).
- When the FIFO is empty, inst holds INST_NOP and inst_pc holds its last value.

Optional Feature:
- Macro: FETCH_BYPASS_EN.
- Defined: when the FIFO is empty, drop==0, no redirect, and imem_rsp_valid, the response drives inst/inst_pc combinationally with inst_valid=1 in the same cycle. If inst_ready, the response is not pushed, so latency is N+1.
- Undefined: every response goes through the FIFO, and the outputs are purely registered from the FIFO head.

Decomposition:
- Add to the shared pipeline header/package:
  - INST_NOP (32'h0000_0013).
  - fetch_state_e {S_IDLE, S_RUN, S_DRAIN}.
  - fetch_entry_t struct {inst, pc}.
- One sub-module: fetch_fifo, a parameterised synchronous FIFO of fetch_entry_t with push/pop/flush/count.
  - Instantiated twice: the instruction buffer, and the PC-tag queue (PC field only used).

Test Plan:
- Reset and stream:
  - Stimulus: RESET_PC=0x100, imem always ready, 1-cycle response, inst_ready=1.
  - Required: imem_req_addr goes 0x100, 0x104, 0x108…; inst_pc follows the same sequence with inst matching memory; first inst_valid 2 cycles after the first request accept.
- Back-pressure:
  - Stimulus: hold inst_ready=0 for 10 cycles.
  - Required: fetch stops after 2 requests; FIFO full; inst stable at PC 0x100.
  - On release, instructions 0x100, 0x104, 0x108 are delivered with no gap or duplicate.
- Redirect with outstanding:
  - Stimulus: 3-cycle response latency, 2 in flight, redirect_pc=0x203.
  - Required: both stale responses dropped; next delivered inst_pc=0x200; no wrong-path inst_valid.
- Redirect coincident with response and pop:
  - Required: the response is discarded, drop=outstanding−1, the decode pop completes, and the next request is to redirect_pc.
- PC wrap:
  - Stimulus: redirect to 0xFFFF_FFFC.
  - Required: the following request address is 0x0000_0000.
- Bypass: with FETCH_BYPASS_EN, an empty FIFO, and inst_ready=1, the response appears on inst in the same cycle as imem_rsp_valid. Without the macro it appears one cycle later.
